icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 8, which sets the number of direct-mapped lines (2^INDEX_BITS, one 32-bit word each).
REQ-002 SHALL have parameter ADDR_BITS, default 18, which sets the significant PC/memory address bits; tag = pc[ADDR_BITS-1 : INDEX_BITS+2].
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 rdy  in  1  global enable; 0 freezes all state.
REQ-006 IF_pc_sgn  in  1  fetcher requests the instruction at IF_pc (level, held while waiting).
REQ-007 IF_pc  in  32  fetch address, word-aligned.
REQ-008 IF_ins_sgn  out  1  one-cycle pulse: IF_ins is valid for the last accepted PC.
REQ-009 IF_ins  out  32  fetched instruction word.
REQ-010 MC_req  out  1  instruction-read request to the memory controller, held until MC_done.
REQ-011 MC_addr  out  32  word address of the miss, stable while MC_req=1.
REQ-012 MC_done  in  1  one-cycle pulse: MC_data holds the requested word.
REQ-013 MC_data  in  32  returned instruction word.
REQ-014 ROB_jp_wrong  in  1  misprediction flush; IF_pc carries the redirect target in the same cycle.

Function
REQ-015 SHALL store per line: valid bit, tag, and 32-bit data.
REQ-016 SHALL implement a three-state FSM: IDLE, MISS, DRAIN.
REQ-017 IDLE: when IF_pc_sgn=1, SHALL accept IF_pc into a request register and look up index pc[INDEX_BITS+1:2].
REQ-018 IDLE hit: SHALL assert IF_sgn_reg with the line data on the next cycle (1-cycle latency) and remain in IDLE; back-to-back hits sustain 1 instruction/cycle.
REQ-019 IDLE miss: SHALL go to MISS and drive MC_req=1, MC_addr = the accepted PC, from the next cycle.
REQ-020 MISS: SHALL ignore IF_pc_sgn; on MC_done, SHALL write valid/tag/data into the line, deassert MC_req, pulse IF_ins_sgn with MC_data on the next cycle, and return to IDLE.
REQ-021 MISS + ROB_jp_wrong without MC_done: SHALL go to DRAIN and keep MC_req/MC_addr unchanged (memory requests are never aborted).
REQ-022 MISS + ROB_jp_wrong + MC_done in the same cycle: SHALL fill the line, return to IDLE, and produce no IF_ins_sgn.
REQ-023 DRAIN: on MC_done, SHALL fill the line, go to IDLE, and produce no IF_ins_sgn; further flushes keep it in DRAIN.
REQ-024 IDLE + ROB_jp_wrong: SHALL cancel any pending output pulse and accept IF_pc (the redirect target) as a normal request in the same cycle.
REQ-025 IF_ins_sgn SHALL equal the registered valid AND rdy; it is never high for more than one rdy-cycle per accepted request.
REQ-026 rdy=0 SHALL block FSM transitions, array writes, and acceptance; MC_req/MC_addr hold their values.
REQ-027 MC_req SHALL be asserted only in MISS or DRAIN; at most one request is outstanding.
REQ-028 IF_pc bits above ADDR_BITS and bits [1:0] SHALL be ignored for the tag and index.

Reset
REQ-029 When rst=0 at a clock edge, SHALL clear all valid bits and set state=IDLE, IF_ins_sgn=0, IF_ins=0, MC_req=0, MC_addr=0, regardless of rdy or any in-flight miss.
REQ-030 A miss in flight at reset SHALL be discarded; any later MC_done while in IDLE SHALL be ignored.

Verification
REQ-031 Cold miss: after reset, IF_pc=0x0 with MC_done three cycles later, data 0x00000013 -> MC_req high for three cycles, MC_addr=0x0, IF_ins_sgn one cycle after MC_done, IF_ins=0x00000013.
REQ-032 Hit streak: lines 0x0 and 0x4 are filled; request 0x0 then 0x4 in consecutive cycles -> IF_ins_sgn high on two consecutive cycles with the correct words and MC_req=0.
REQ-033 Conflict: fill 0x0, then request 0x400 (same index, different tag) -> miss with MC_addr=0x400; a subsequent request to 0x0 misses again.
REQ-034 Flush during miss: miss on 0x100, ROB_jp_wrong one cycle later, MC_done two cycles after that -> no IF_ins_sgn, line 0x100 becomes valid, FSM in IDLE; the next request to 0x100 hits.
REQ-035 Simultaneous flush + MC_done in MISS -> fill occurs, no IF_ins_sgn, the request on the following cycle is accepted.
REQ-036 rdy low for two cycles during a hit response -> IF_ins_sgn=0 while rdy=0, then exactly one pulse when rdy returns to 1; no state change while frozen.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and memory-controller-side handshake bundle for the instruction cache.
interface icache_if;
  logic        IF_pc_sgn;
  logic [31:0] IF_pc;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_done;
  logic [31:0] MC_data;
  logic        ROB_jp_wrong;

  modport slave (
    input  IF_pc_sgn, IF_pc, MC_done, MC_data, ROB_jp_wrong,
    output IF_ins_sgn, IF_ins, MC_req, MC_addr
  );

  modport master (
    output IF_pc_sgn, IF_pc, MC_done, MC_data, ROB_jp_wrong,
    input  IF_ins_sgn, IF_ins, MC_req, MC_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// A flush during a miss lets the memory read complete (DRAIN) but suppresses the response.
module icache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_BITS  = 18
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  icache_if.slave  bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, MISS, DRAIN} state_t;

  state_t                state, state_next;
  logic [LINES-1:0]      valid_arr;
  logic [TAG_BITS-1:0]   tag_arr  [LINES];
  logic [31:0]           data_arr [LINES];

  logic                  out_valid, out_valid_next;
  logic [31:0]           ins_q, ins_next;
  logic                  mc_req_q, mc_req_next;
  logic [31:0]           mc_addr_q, mc_addr_next;
  logic                  fill_en;

  logic [INDEX_BITS-1:0] lookup_idx, fill_idx;
  logic [TAG_BITS-1:0]   lookup_tag, fill_tag;
  logic                  lookup_hit;

  assign lookup_idx = bus.IF_pc[INDEX_BITS+1:2];
  assign lookup_tag = bus.IF_pc[ADDR_BITS-1:INDEX_BITS+2];
  assign lookup_hit = valid_arr[lookup_idx] && (tag_arr[lookup_idx] == lookup_tag);

  // The miss address register doubles as the fill address for the line being refilled.
  assign fill_idx = mc_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mc_addr_q[ADDR_BITS-1:INDEX_BITS+2];

  assign bus.IF_ins_sgn = out_valid && rdy;
  assign bus.IF_ins     = ins_q;
  assign bus.MC_req     = mc_req_q;
  assign bus.MC_addr    = mc_addr_q;

  always_comb begin
    state_next     = state;
    out_valid_next = 1'b0;
    ins_next       = ins_q;
    mc_req_next    = mc_req_q;
    mc_addr_next   = mc_addr_q;
    fill_en        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.IF_pc_sgn || bus.ROB_jp_wrong) begin
          if (lookup_hit) begin
            out_valid_next = 1'b1;
            ins_next       = data_arr[lookup_idx];
          end else begin
            state_next   = MISS;
            mc_req_next  = 1'b1;
            mc_addr_next = bus.IF_pc;
          end
        end
      end
      MISS: begin
        if (bus.MC_done) begin
          fill_en     = 1'b1;
          mc_req_next = 1'b0;
          state_next  = IDLE;
          if (!bus.ROB_jp_wrong) begin
            out_valid_next = 1'b1;
            ins_next       = bus.MC_data;
          end
        end else if (bus.ROB_jp_wrong) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.MC_done) begin
          fill_en     = 1'b1;
          mc_req_next = 1'b0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // With rdy low everything holds, including a pending response pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      valid_arr <= '0;
      out_valid <= 1'b0;
      ins_q     <= '0;
      mc_req_q  <= 1'b0;
      mc_addr_q <= '0;
    end else if (rdy) begin
      state     <= state_next;
      out_valid <= out_valid_next;
      ins_q     <= ins_next;
      mc_req_q  <= mc_req_next;
      mc_addr_q <= mc_addr_next;
      if (fill_en) valid_arr[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy && fill_en) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= bus.MC_data;
    end
  end
endmodule

// File: tb/tb_icache.sv
// Directed and randomized fetch sequences for icache, checked against a per-line
// valid/tag/data model indexed by plain address arithmetic.
module tb_icache;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;

  bit          mvalid [256];
  int          mtag   [256];
  logic [31:0] mdata  [256];

  icache_if bus ();

  icache #(.INDEX_BITS(8), .ADDR_BITS(18)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sgn, input logic [31:0] pc, input logic done,
                               input logic [31:0] data, input logic jp);
    bus.IF_pc_sgn    = sgn;
    bus.IF_pc        = pc;
    bus.MC_done      = done;
    bus.MC_data      = data;
    bus.ROB_jp_wrong = jp;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic obs, input logic exp);
    checkOutput(name, {31'b0, obs}, {31'b0, exp});
  endtask

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hFF);
  endfunction

  function automatic int tagOf(input logic [31:0] pc);
    return int'((pc >> 10) & 32'hFF);
  endfunction

  task automatic modelFill(input logic [31:0] pc, input logic [31:0] d);
    mvalid[idxOf(pc)] = 1'b1;
    mtag[idxOf(pc)]   = tagOf(pc);
    mdata[idxOf(pc)]  = d;
  endtask

  // flushAt: 0 = redirect on the accepting cycle, 1..lat = flush on that wait cycle
  // (lat means together with MC_done), -1 = no flush.
  task automatic doFetch(input logic [31:0] pc, input int lat, input int flushAt,
                         input logic [31:0] d);
    bit hit;
    bit flushed;
    hit     = mvalid[idxOf(pc)] && (mtag[idxOf(pc)] == tagOf(pc));
    flushed = 1'b0;
    applyStimulus(1'b1, pc, 1'b0, 32'h0, flushAt == 0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    if (hit) begin
      checkFlag("hit_sgn", bus.IF_ins_sgn, 1'b1);
      checkOutput("hit_ins", bus.IF_ins, mdata[idxOf(pc)]);
      checkFlag("hit_req", bus.MC_req, 1'b0);
      tick();
      checkFlag("hit_pulse_end", bus.IF_ins_sgn, 1'b0);
    end else begin
      checkFlag("miss_req", bus.MC_req, 1'b1);
      checkOutput("miss_addr", bus.MC_addr, pc);
      checkFlag("miss_sgn", bus.IF_ins_sgn, 1'b0);
      for (int c = 1; c <= lat; c++) begin
        applyStimulus(1'($urandom_range(0, 1)), $urandom, c == lat,
                      (c == lat) ? d : $urandom, c == flushAt);
        if (c == flushAt) flushed = 1'b1;
        tick();
        if (c < lat) begin
          checkFlag("wait_req", bus.MC_req, 1'b1);
          checkOutput("wait_addr", bus.MC_addr, pc);
          checkFlag("wait_sgn", bus.IF_ins_sgn, 1'b0);
        end
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkFlag("fill_req", bus.MC_req, 1'b0);
      checkFlag("fill_sgn", bus.IF_ins_sgn, !flushed);
      if (!flushed) checkOutput("fill_ins", bus.IF_ins, d);
      modelFill(pc, d);
      tick();
      checkFlag("after_fill_sgn", bus.IF_ins_sgn, 1'b0);
      checkFlag("after_fill_req", bus.MC_req, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] pc;
    int          lat;
    int          r;
    int          fl;

    foreach (mvalid[i]) mvalid[i] = 1'b0;

    // Reset must take effect even with rdy low.
    rst = 1'b0;
    rdy = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    rdy = 1'b1;
    tick();
    checkFlag("rst_sgn", bus.IF_ins_sgn, 1'b0);
    checkOutput("rst_ins", bus.IF_ins, 32'h0);
    checkFlag("rst_req", bus.MC_req, 1'b0);
    checkOutput("rst_addr", bus.MC_addr, 32'h0);
    rst = 1'b1;

    // Cold miss with three-cycle memory latency.
    doFetch(32'h0, 3, -1, 32'h0000_0013);

    // Back-to-back hits.
    doFetch(32'h4, 2, -1, 32'hA5A5_0004);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkFlag("streak0_sgn", bus.IF_ins_sgn, 1'b1);
    checkOutput("streak0_ins", bus.IF_ins, 32'h0000_0013);
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
    tick();
    checkFlag("streak1_sgn", bus.IF_ins_sgn, 1'b1);
    checkOutput("streak1_ins", bus.IF_ins, 32'hA5A5_0004);
    checkFlag("streak_req", bus.MC_req, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkFlag("streak_end", bus.IF_ins_sgn, 1'b0);

    // Conflict on index 0.
    doFetch(32'h400, 2, -1, 32'h0000_0400);
    doFetch(32'h0, 1, -1, 32'h0000_1013);

    // Flush during miss, then the drained line hits.
    doFetch(32'h100, 3, 1, 32'hCAFE_0100);
    doFetch(32'h100, 1, -1, 32'h0);

    // Redirect accepted as a request while idle.
    doFetch(32'h2000, 2, 0, 32'h0000_2000);

    // Flush coinciding with MC_done, request accepted on the very next cycle.
    applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    tick();
    checkFlag("sim_req", bus.MC_req, 1'b1);
    checkOutput("sim_addr", bus.MC_addr, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h8, 1'b1, 32'h1234_5678, 1'b1);
    tick();
    checkFlag("sim_fill_sgn", bus.IF_ins_sgn, 1'b0);
    checkFlag("sim_fill_req", bus.MC_req, 1'b0);
    modelFill(32'h200, 32'h1234_5678);
    applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    tick();
    checkFlag("sim_next_sgn", bus.IF_ins_sgn, 1'b1);
    checkOutput("sim_next_ins", bus.IF_ins, 32'h1234_5678);
    checkFlag("sim_next_req", bus.MC_req, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();

    // rdy low across a hit response; an uncached request during the freeze is not accepted.
    applyStimulus(1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
    tick();
    rdy = 1'b0;
    applyStimulus(1'b1, 32'h3000, 1'b0, 32'h0, 1'b0);
    #1;
    checkFlag("frz_sgn_a", bus.IF_ins_sgn, 1'b0);
    tick();
    checkFlag("frz_sgn_b", bus.IF_ins_sgn, 1'b0);
    checkFlag("frz_req_b", bus.MC_req, 1'b0);
    tick();
    checkFlag("frz_sgn_c", bus.IF_ins_sgn, 1'b0);
    checkFlag("frz_req_c", bus.MC_req, 1'b0);
    rdy = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checkFlag("thaw_sgn", bus.IF_ins_sgn, 1'b1);
    checkOutput("thaw_ins", bus.IF_ins, mdata[idxOf(32'h4)]);
    tick();
    checkFlag("thaw_once", bus.IF_ins_sgn, 1'b0);
    checkFlag("thaw_req", bus.MC_req, 1'b0);

    // Reset with a miss in flight; a late MC_done is ignored and all lines are invalid.
    applyStimulus(1'b1, 32'h5000, 1'b0, 32'h0, 1'b0);
    tick();
    checkFlag("inflight_req", bus.MC_req, 1'b1);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    checkFlag("rst2_req", bus.MC_req, 1'b0);
    checkOutput("rst2_addr", bus.MC_addr, 32'h0);
    checkOutput("rst2_ins", bus.IF_ins, 32'h0);
    checkFlag("rst2_sgn", bus.IF_ins_sgn, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    checkFlag("late_done_req", bus.MC_req, 1'b0);
    checkFlag("late_done_sgn", bus.IF_ins_sgn, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    doFetch(32'h4, 2, -1, 32'h0BAD_0004);

    // Random traffic over a small address pool; high and low pc bits are noise.
    for (int i = 0; i < 80; i++) begin
      pc = ($urandom & 32'hFFFC_0003) | (32'($urandom_range(0, 7)) << 2)
           | (32'($urandom_range(0, 3)) << 10);
      lat = $urandom_range(1, 4);
      r = $urandom_range(0, 5);
      fl = (r == 0) ? 0 : (r == 1) ? lat : (r == 2) ? 1 : -1;
      doFetch(pc, lat, fl, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
